lockstep_alu_checker: RTL

- Parametrised, registered successor to the dual-ALU XOR fault checker.
- Two redundant ALU lanes (primary and shadow) each take their own operands and opcode, and both execute on the same accepted beat.
- Results are compared in a registered output stage with a valid/ready handshake.
- A saturating fault counter, a consecutive-mismatch counter and a lockout state machine replace the simulation-only fault print.

---
 rtl/lockstep_alu_checker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/lockstep_alu_checker.sv
// Dual-lane lockstep ALU with a registered compare stage, valid/ready handshake,
// saturating fault accounting and a RUN/SUSPECT/LOCKED lockout machine.
module lockstep_alu_checker #(
    parameter int WIDTH       = 8,
    parameter int CNT_W       = 8,
    parameter int LOCK_THRESH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [2:0]       sel0,
    input  logic [2:0]       sel1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic [WIDTH-1:0] diff,
    output logic             mismatch,
    output logic [CNT_W-1:0] fault_cnt,
    output logic             locked,
    input  logic             clear
);

    typedef enum logic [1:0] {
        RUN,
        SUSPECT,
        LOCKED
    } state_t;

    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(LOCK_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Returns {carry, result}; every opcode is evaluated one bit wider than the operands.
    function automatic logic [WIDTH:0] alu_op(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [2:0]       sel
    );
        logic [WIDTH:0] r;
        // NOTE: r is given a value on every path (default arm), so no latch is inferred.
        case (sel)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} - {1'b0, b};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {a, 1'b0};
            3'b110:  r = {a[0], 1'b0, a[WIDTH-1:1]};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    state_t           state;
    logic [CNT_W-1:0] consec;
    logic [CNT_W-1:0] consec_inc;
    logic [CNT_W-1:0] fault_inc;
    logic [WIDTH:0]   lane0;
    logic [WIDTH:0]   lane1;
    logic             beat_mismatch;
    logic             accept;

    assign lane0         = alu_op(a0, b0, sel0);
    assign lane1         = alu_op(a1, b1, sel1);
    assign beat_mismatch = (lane0 != lane1);

    assign in_ready = !locked && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    assign consec_inc = (consec == CNT_MAX) ? consec : consec + 1'b1;
    assign fault_inc  = (fault_cnt == CNT_MAX) ? fault_cnt : fault_cnt + 1'b1;

    // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            diff      <= '0;
            mismatch  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= lane0[WIDTH-1:0];
            carry     <= lane0[WIDTH];
            diff      <= lane0[WIDTH-1:0] ^ lane1[WIDTH-1:0];
            mismatch  <= beat_mismatch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // clear outranks an accept: the beat is still reported above but never counted here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            consec    <= '0;
            fault_cnt <= '0;
            locked    <= 1'b0;
        end else if (clear) begin
            state     <= RUN;
            consec    <= '0;
            fault_cnt <= '0;
            locked    <= 1'b0;
        end else if (accept) begin
            if (beat_mismatch) begin
                fault_cnt <= fault_inc;
                consec    <= consec_inc;
                if (consec_inc >= THRESH) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                end else begin
                    state  <= SUSPECT;
                end
            end else begin
                consec <= '0;
                state  <= RUN;
            end
        end
    end

endmodule
